// File: rtl/sw_debouncer.sv
// Switch input conditioner: two-flop synchroniser plus per-bit stability counter,
// giving a settled switch vector and one-cycle rise/fall/change strobes.
//
// Per-bit state (implicit in cnt):
//   state    | meaning
//   STABLE   | cnt == 0, sync2 agrees with sw_db
//   COUNTING | sync2 disagrees, cnt counting consecutive mismatch cycles
//   ACCEPT   | cnt == DB_CYCLES-1 with mismatch: sw_db takes sync2, strobe fires
module sw_debouncer #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);

    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             chg_q, chg_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    always_comb begin
        sync1_d = sw_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            // Counter only runs while the synchronised level disagrees with sw_db.
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]   = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        chg_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            chg_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            chg_q   <= chg_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_db   = db_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
    assign sw_chg  = chg_q;

endmodule

// File: tb/tb_sw_debouncer.sv
// Bench for sw_debouncer: directed scenarios plus random switch activity, all
// checked cycle by cycle against a history-window reference model.
module tb_sw_debouncer;

    localparam int W  = 4;
    localparam int DB = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_db, sw_rise, sw_fall;
    logic         sw_chg;

    sw_debouncer #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .sw_db  (sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_chg (sw_chg)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a bit is accepted once the last DB synchronised samples
    // all differ from its current debounced value.
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_rise = '0, m_fall = '0;
    logic         m_chg = 1'b0;
    logic [W-1:0] hist[$];

    int strobe_cnt;
    int rise2_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_edge(input logic r, input logic [W-1:0] v);
        bit all_diff;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > DB) void'(hist.pop_front());
            m_rise = '0;
            m_fall = '0;
            if (hist.size() == DB) begin
                for (int i = 0; i < W; i++) begin
                    all_diff = 1'b1;
                    foreach (hist[j]) if (hist[j][i] == m_db[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_db[i] = ~m_db[i];
                        if (m_db[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                    end
                end
            end
            m_chg = |(m_rise | m_fall);
            m_s2  = m_s1;
            m_s1  = v;
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] v);
        @(negedge clk);
        rst   = r;
        sw_in = v;
        @(posedge clk);
        model_edge(r, v);
        #1;
        chk("sw_db",   32'(sw_db),   32'(m_db));
        chk("sw_rise", 32'(sw_rise), 32'(m_rise));
        chk("sw_fall", 32'(sw_fall), 32'(m_fall));
        chk("sw_chg",  32'(sw_chg),  32'(m_chg));
        if (sw_chg || (sw_rise != 0) || (sw_fall != 0)) strobe_cnt++;
        if (sw_rise[2]) rise2_cnt++;
    endtask

    // Drives v (rst low) and returns how many edges, counting the first one,
    // it takes for sw_db to read exp; bounded at 60.
    task automatic settle_count(input logic [W-1:0] v, input logic [W-1:0] exp, output int n);
        n = 0;
        do begin
            step(1'b0, v);
            n++;
        end while (sw_db != exp && n < 60);
    endtask

    task automatic hold(input logic [W-1:0] v, input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, v);
    endtask

    initial begin
        int n;
        logic [W-1:0] v;
        int len;

        // Reset with all switches high; outputs must stay 0.
        for (int k = 0; k < 3; k++) step(1'b1, 4'hF);
        chk("reset_db", 32'(sw_db), 32'h0);
        chk("reset_chg", 32'(sw_chg), 32'h0);
        settle_count(4'hF, 4'hF, n);
        chk("release_latency", 32'(n), 32'd18);
        chk("release_rise", 32'(sw_rise), 32'hF);
        chk("release_chg", 32'(sw_chg), 32'h1);
        step(1'b0, 4'hF);
        chk("release_rise_one_cycle", 32'(sw_rise), 32'h0);

        // Glitch shorter than the window.
        hold(4'h0, 25);
        strobe_cnt = 0;
        hold(4'h1, 10);
        hold(4'h0, 25);
        chk("glitch_db", 32'(sw_db), 32'h0);
        chk("glitch_strobes", 32'(strobe_cnt), 32'd0);

        // Bounce on bit 2, then hold high.
        rise2_cnt = 0;
        for (int k = 0; k < 10; k++) hold((k % 2 == 0) ? 4'h4 : 4'h0, 3);
        settle_count(4'h4, 4'h4, n);
        chk("bounce_latency", 32'(n), 32'd18);
        hold(4'h4, 5);
        chk("bounce_single_rise", 32'(rise2_cnt), 32'd1);

        // Fall of bit 0 from a settled 5.
        hold(4'h5, 25);
        chk("pre_fall_db", 32'(sw_db), 32'h5);
        settle_count(4'h4, 4'h4, n);
        chk("fall_latency", 32'(n), 32'd18);
        chk("fall_strobe", 32'(sw_fall), 32'h1);
        chk("fall_norise", 32'(sw_rise), 32'h0);

        // Simultaneous rise on bits 3 and 1.
        hold(4'h0, 25);
        settle_count(4'hA, 4'hA, n);
        chk("simul_latency", 32'(n), 32'd18);
        chk("simul_rise", 32'(sw_rise), 32'hA);
        chk("simul_chg", 32'(sw_chg), 32'h1);

        // Reset mid-count.
        hold(4'h0, 25);
        hold(4'hF, 10);
        step(1'b1, 4'hF);
        chk("midrst_db", 32'(sw_db), 32'h0);
        settle_count(4'hF, 4'hF, n);
        chk("midrst_latency", 32'(n), 32'd18);

        // Toggle every cycle: nothing may ever be accepted.
        strobe_cnt = 0;
        for (int k = 0; k < 100; k++) step(1'b0, (k % 2 == 0) ? 4'h0 : 4'hF);
        chk("toggle_strobes", 32'(strobe_cnt), 32'd0);
        chk("toggle_db", 32'(sw_db), 32'hF);

        // Random hold lengths straddling the window, with rare resets.
        for (int k = 0; k < 150; k++) begin
            v   = W'($urandom);
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 40) == 0) step(1'b1, v);
            hold(v, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
